// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetches 16-bit instructions from program memory into the instruction
//   register (IR). Each instruction is handed to the datapath controller with
//   a one-cycle start pulse. The unit then tracks the controller's idle flag
//   (w) until the controller returns to its wait state. The register-select
//   and immediate fields are decoded combinationally from the IR.
//
//   Ports
//     clk, rst             clock; asynchronous active-low reset
//     run                  fetch enable (only looked at when idle or between instructions)
//     w                    controller idle flag
//     mem_req/mem_addr     program-memory read request and address (= pc)
//     mem_ack/mem_rdata    read handshake and instruction word
//     s                    start pulse to the controller
//     opcode, op, shift    raw IR fields
//     nsel/regnum          one-hot register select in, register number out
//     sximm8, sximm5       sign-extended immediates
//     pc                   address of the next instruction
//     halted, err          sticky status flags (halt fetched / controller timeout)
module instr_fetch_unit #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              w,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              s,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  input  logic [2:0]        nsel,
  output logic [2:0]        regnum,
  output logic [1:0]        shift,
  output logic [15:0]       sximm8,
  output logic [15:0]       sximm5,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err
);

  localparam int unsigned CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [2:0]  OPC_HALT = 3'b111;

  typedef enum logic [2:0] {
    F_IDLE,
    F_REQ,
    F_LATCH,
    F_ISSUE,
    F_WAIT_BUSY,
    F_WAIT_DONE,
    F_HALT
  } state_t;

  state_t           state;
  logic [15:0]      ir;
  logic [CNT_W-1:0] cnt;

  // Fetch sequencer; every status output is driven from this register block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= F_IDLE;
      pc      <= ADDR_W'(RESET_PC);
      ir      <= 16'h0000;
      cnt     <= '0;
      s       <= 1'b0;
      mem_req <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      s <= 1'b0;
      case (state)
        F_IDLE: begin
          if (run && w) begin
            state   <= F_REQ;
            mem_req <= 1'b1;
          end
        end
        F_REQ: begin
          // Request stays up until acknowledged; run cannot abort it
          if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc + ADDR_W'(1);
            mem_req <= 1'b0;
            state   <= F_LATCH;
          end
        end
        F_LATCH: begin
          if (ir[15:13] == OPC_HALT) begin
            halted <= 1'b1;
            state  <= F_HALT;
          end else begin
            s     <= 1'b1;
            state <= F_ISSUE;
          end
        end
        F_ISSUE: begin
          cnt   <= '0;
          state <= F_WAIT_BUSY;
        end
        F_WAIT_BUSY: begin
          // Controller must leave its wait state within BUSY_TIMEOUT cycles
          if (!w) begin
            state <= F_WAIT_DONE;
          end else if (32'(cnt) == BUSY_TIMEOUT - 1) begin
            err    <= 1'b1;
            halted <= 1'b1;
            state  <= F_HALT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        F_WAIT_DONE: begin
          if (w) begin
            if (run) begin
              mem_req <= 1'b1;
              state   <= F_REQ;
            end else begin
              state <= F_IDLE;
            end
          end
        end
        F_HALT: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= F_IDLE;
        end
      endcase
    end
  end

  assign mem_addr = pc;
  assign opcode   = ir[15:13];
  assign op       = ir[12:11];
  assign shift    = ir[4:3];
  assign sximm8   = {{8{ir[7]}}, ir[7:0]};
  assign sximm5   = {{11{ir[4]}}, ir[4:0]};

  // One-hot register select; anything else reads as register 0
  always_comb begin
    regnum = 3'd0;
    case (nsel)
      3'b100:  regnum = ir[7:5];
      3'b010:  regnum = ir[10:8];
      3'b001:  regnum = ir[2:0];
      default: regnum = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder and controller are modelled in
// tasks; fetched words go into a scoreboard queue and are popped on each s.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        w;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        s;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  nsel;
  logic [2:0]  regnum;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [7:0]  pc;
  logic        halted;
  logic        err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(0), .BUSY_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .w(w),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .s(s), .opcode(opcode), .op(op), .nsel(nsel), .regnum(regnum), .shift(shift),
    .sximm8(sximm8), .sximm5(sximm5), .pc(pc), .halted(halted), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    mem_ack = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // mode 0: full handshake, returns in WAIT_DONE with w=1
  // mode 1: returns in ISSUE with w held at 1
  // mode 2: returns in WAIT_DONE with w still 0
  task automatic fetch_one(input logic [15:0] data, input int delay, input bit toggle_run, input int mode);
    logic [7:0]  a0;
    logic [7:0]  ea;
    logic [15:0] e;
    int k;
    k = 0;
    nsel = 3'b010;
    while (mem_req !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL req_wait mem_req=%b expected 1", mem_req);
      return;
    end
    a0 = mem_addr;
    for (int i = 0; i < delay; i++) begin
      if (toggle_run) run = ~run;
      step();
      checks++;
      if (mem_req !== 1'b1 || s !== 1'b0 || mem_addr !== a0) begin
        failures++;
        $display("FAIL req_hold mem_req=%b s=%b addr=%h expected 1 0 %h", mem_req, s, mem_addr, a0);
      end
    end
    run = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = data;
    if (data[15:13] != 3'b111) sb.push_back(data);
    step();
    mem_ack = 1'b0;
    mem_rdata = 16'($urandom);
    ea = a0 + 8'd1;
    checks++;
    if (mem_req !== 1'b0 || s !== 1'b0 || pc !== ea) begin
      failures++;
      $display("FAIL accept mem_req=%b s=%b pc=%h expected 0 0 %h", mem_req, s, pc, ea);
    end
    if (data[15:13] == 3'b111) return;
    step();
    checks++;
    if (s !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL issue s=%b mem_req=%b expected 1 0", s, mem_req);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty size=0 expected entry");
    end else begin
      e = sb.pop_front();
      checks++;
      if (opcode !== e[15:13] || op !== e[12:11] || shift !== e[4:3]) begin
        failures++;
        $display("FAIL fields opc/op/sh=%h/%h/%h expected %h/%h/%h", opcode, op, shift, e[15:13], e[12:11], e[4:3]);
      end
      checks++;
      if (sximm8 !== {{8{e[7]}}, e[7:0]} || sximm5 !== {{11{e[4]}}, e[4:0]}) begin
        failures++;
        $display("FAIL imm sximm8=%h sximm5=%h for ir=%h", sximm8, sximm5, e);
      end
      checks++;
      if (regnum !== e[10:8]) begin
        failures++;
        $display("FAIL regnum_rn regnum=%0d expected %0d", regnum, e[10:8]);
      end
    end
    if (mode == 1) return;
    w = 1'b0;
    step();
    checks++;
    if (s !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL busy s=%b mem_req=%b expected 0 0", s, mem_req);
    end
    step();
    checks++;
    if (s !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL done s=%b mem_req=%b expected 0 0", s, mem_req);
    end
    if (mode == 2) return;
    w = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    step();
    checks++;
    if (mem_req !== 1'b0 || s !== 1'b0 || pc !== 8'h00 || mem_addr !== 8'h00 ||
        halted !== 1'b0 || err !== 1'b0 || opcode !== 3'd0 || sximm8 !== 16'h0000) begin
      failures++;
      $display("FAIL reset req=%b s=%b pc=%h halted=%b err=%b opc=%h imm8=%h expected all zero",
               mem_req, s, pc, halted, err, opcode, sximm8);
    end
  endtask

  task automatic test_fetch_decode();
    run = 1'b1;
    w = 1'b1;
    fetch_one(16'hD105, 0, 1'b0, 0);
    checks++;
    if (opcode !== 3'd6 || op !== 2'd2 || regnum !== 3'd1 || sximm8 !== 16'h0005 || pc !== 8'h01) begin
      failures++;
      $display("FAIL d105 opc=%0d op=%0d regnum=%0d imm8=%h pc=%h expected 6 2 1 0005 01",
               opcode, op, regnum, sximm8, pc);
    end
  endtask

  task automatic test_regnum();
    logic [2:0] sel_tab[6] = '{3'b100, 3'b001, 3'b011, 3'b010, 3'b000, 3'b111};
    logic [2:0] exp_tab[6] = '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    fetch_one(16'hA0E8, 0, 1'b0, 2);
    for (int i = 0; i < 6; i++) begin
      nsel = sel_tab[i];
      #1;
      checks++;
      if (regnum !== exp_tab[i]) begin
        failures++;
        $display("FAIL regnum_sel nsel=%b regnum=%0d expected %0d", nsel, regnum, exp_tab[i]);
      end
    end
    checks++;
    if (sximm8 !== 16'hFFE8 || sximm5 !== 16'h0008 || shift !== 2'd1) begin
      failures++;
      $display("FAIL a0e8_imm imm8=%h imm5=%h shift=%0d expected FFE8 0008 1", sximm8, sximm5, shift);
    end
    nsel = 3'b010;
    w = 1'b1;
  endtask

  task automatic test_back_to_back();
    fetch_one(16'h4123, 5, 1'b1, 0);
    for (int i = 0; i < 4; i++)
      fetch_one({3'(i), 13'($urandom)}, i % 3, 1'b0, 0);
  endtask

  task automatic test_wrap_halt();
    apply_reset();
    run = 1'b1;
    w = 1'b1;
    for (int i = 0; i < 255; i++)
      fetch_one({3'(i % 7), 13'($urandom)}, 0, 1'b0, 0);
    checks++;
    if (pc !== 8'hFF) begin
      failures++;
      $display("FAIL pc_ff pc=%h expected FF", pc);
    end
    fetch_one(16'hE000, 0, 1'b0, 0);
    checks++;
    if (pc !== 8'h00) begin
      failures++;
      $display("FAIL pc_wrap pc=%h expected 00", pc);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (halted !== 1'b1 || s !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0) begin
        failures++;
        $display("FAIL halt halted=%b s=%b req=%b err=%b expected 1 0 0 0", halted, s, mem_req, err);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    run = 1'b1;
    w = 1'b1;
    fetch_one(16'h2222, 0, 1'b0, 1);
    step();
    for (int i = 1; i <= 14; i++) begin
      step();
      checks++;
      if (err !== 1'b0 || halted !== 1'b0) begin
        failures++;
        $display("FAIL timeout_early cycle=%0d err=%b halted=%b expected 0 0", i, err, halted);
      end
    end
    step();
    checks++;
    if (err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0 || s !== 1'b0) begin
      failures++;
      $display("FAIL timeout err=%b halted=%b req=%b s=%b expected 1 1 0 0", err, halted, mem_req, s);
    end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL async_flags halted=%b err=%b expected 0 0", halted, err);
    end
    step();
    rst = 1'b1;
    run = 1'b1;
    w = 1'b1;
    fetch_one(16'h1111, 0, 1'b0, 0);
    step();
    checks++;
    if (mem_req !== 1'b1 || pc !== 8'h01) begin
      failures++;
      $display("FAIL pre_reset_req req=%b pc=%h expected 1 01", mem_req, pc);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== 8'h00 || s !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL async_req req=%b pc=%h s=%b halted=%b expected 0 00 0 0", mem_req, pc, s, halted);
    end
    run = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hE000;
    #2 rst = 1'b1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0 || opcode !== 3'd0 || pc !== 8'h00 || halted !== 1'b0) begin
      failures++;
      $display("FAIL late_ack req=%b opc=%0d pc=%h halted=%b expected 0 0 00 0", mem_req, opcode, pc, halted);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_run_idle();
    run = 1'b1;
    w = 1'b1;
    fetch_one(16'h3333, 0, 1'b0, 2);
    run = 1'b0;
    w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (mem_req !== 1'b0 || s !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold req=%b s=%b expected 0 0", mem_req, s);
      end
    end
    run = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== pc) begin
      failures++;
      $display("FAIL idle_resume req=%b addr=%h expected 1 %h", mem_req, mem_addr, pc);
    end
    fetch_one(16'h5555, 0, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;
    w = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    nsel = 3'b010;
    test_reset();
    test_fetch_decode();
    test_regnum();
    test_back_to_back();
    test_wrap_halt();
    test_timeout();
    test_async_reset();
    test_run_idle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover size=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
